// File: rtl/systolic_pkg.sv
// Shared types and default widths for the systolic MAC processing element.
// Optional saturation is selected with SYSTOLIC_PE_SATURATE_EN.
package systolic_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_ACC_W  = 24;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DRAIN = 2'd2
    } pe_state_t;

endpackage

// File: rtl/systolic_mac_sat.sv
// Combinational signed multiply-accumulate with overflow detection.
// SYSTOLIC_PE_SATURATE_EN selects clamping; otherwise the sum wraps.
module systolic_mac_sat
    import systolic_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ACC_W  = DEF_ACC_W
) (
    input  logic [ACC_W-1:0]  acc,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [ACC_W-1:0]  sum,
    output logic              ovf
);

    localparam int PW = 2 * DATA_W;

    logic signed [PW-1:0]    prod;
    logic signed [ACC_W-1:0] prod_x;

    assign prod   = PW'($signed(a)) * PW'($signed(b));
    assign prod_x = ACC_W'(prod);

`ifdef SYSTOLIC_PE_SATURATE_EN
    // One guard bit: a mismatch with the sign bit means the true sum left range.
    logic signed [ACC_W:0] wide;

    assign wide = (ACC_W+1)'($signed(acc)) + (ACC_W+1)'(prod_x);

    always_comb begin
        sum = wide[ACC_W-1:0];
        ovf = wide[ACC_W] ^ wide[ACC_W-1];
        if (ovf) begin
            if (wide[ACC_W]) begin
                sum = {1'b1, {(ACC_W-1){1'b0}}};
            end else begin
                sum = {1'b0, {(ACC_W-1){1'b1}}};
            end
        end
    end
`else
    assign sum = acc + prod_x;
    assign ovf = 1'b0;
`endif

endmodule

// File: rtl/systolic_mac_pe.sv
// Systolic array PE: operand forwarding, local MAC, daisy-chained drain.
// SYSTOLIC_PE_SATURATE_EN enables clamping and the sticky ovf flag.
module systolic_mac_pe
    import systolic_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ACC_W  = DEF_ACC_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic [DATA_W-1:0] a_in,
    input  logic              a_vld_in,
    output logic [DATA_W-1:0] a_out,
    output logic              a_vld_out,
    input  logic [DATA_W-1:0] b_in,
    input  logic              b_vld_in,
    output logic [DATA_W-1:0] b_out,
    output logic              b_vld_out,
    input  logic              clr,
    input  logic              drain,
    input  logic [ACC_W-1:0]  d_in,
    input  logic              d_vld_in,
    output logic [ACC_W-1:0]  d_out,
    output logic              d_vld_out,
    output logic              busy,
    output logic              ovf
);

    pe_state_t        state_q;
    pe_state_t        state_d;
    logic [ACC_W-1:0] acc_q;
    logic [ACC_W-1:0] acc_d;
    logic [ACC_W-1:0] sum;
    logic [ACC_W-1:0] d_out_d;
    logic             d_vld_d;
    logic             ovf_q;
    logic             ovf_d;
    logic             mac;
    logic             mac_ovf;

    systolic_mac_sat #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W)
    ) u_mac (
        .acc (acc_q),
        .a   (a_in),
        .b   (b_in),
        .sum (sum),
        .ovf (mac_ovf)
    );

    assign mac  = a_vld_in & b_vld_in;
    assign busy = (state_q != IDLE);
    assign ovf  = ovf_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_out     <= '0;
            a_vld_out <= 1'b0;
            b_out     <= '0;
            b_vld_out <= 1'b0;
        end else if (ena) begin
            a_out     <= a_in;
            a_vld_out <= a_vld_in;
            b_out     <= b_in;
            b_vld_out <= b_vld_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            acc_q     <= '0;
            ovf_q     <= 1'b0;
            d_out     <= '0;
            d_vld_out <= 1'b0;
        end else if (ena) begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            ovf_q     <= ovf_d;
            d_out     <= d_out_d;
            d_vld_out <= d_vld_d;
        end
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        ovf_d   = ovf_q;
        d_out_d = d_out;
        d_vld_d = 1'b0;
        if (clr) begin
            state_d = IDLE;
            acc_d   = '0;
            ovf_d   = 1'b0;
        end else begin
            unique case (state_q)
                IDLE, ACCUM: begin
                    if (mac) begin
                        acc_d   = sum;
                        ovf_d   = ovf_q | mac_ovf;
                        state_d = ACCUM;
                    end
                    // The drained value includes a MAC landing this cycle.
                    if (drain) begin
                        d_out_d = acc_d;
                        d_vld_d = 1'b1;
                        acc_d   = '0;
                        state_d = DRAIN;
                    end
                end
                DRAIN: begin
                    d_vld_d = d_vld_in;
                    if (d_vld_in) begin
                        d_out_d = d_in;
                    end else begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_systolic_mac_pe.sv
// Self-checking bench for systolic_mac_pe: random stimulus vs behavioural model.
// Honours SYSTOLIC_PE_SATURATE_EN for the expected overflow behaviour.
module tb_systolic_mac_pe;

    localparam int AW = 24;
    localparam longint MAXV = 2**(AW-1) - 1;
    localparam longint MINV = -(2**(AW-1));
    localparam longint MODV = 2**AW;

    logic          clk;
    logic          rst_n;
    logic          ena;
    logic [7:0]    a_in;
    logic          a_vld_in;
    logic [7:0]    a_out;
    logic          a_vld_out;
    logic [7:0]    b_in;
    logic          b_vld_in;
    logic [7:0]    b_out;
    logic          b_vld_out;
    logic          clr;
    logic          drain;
    logic [AW-1:0] d_in;
    logic          d_vld_in;
    logic [AW-1:0] d_out;
    logic          d_vld_out;
    logic          busy;
    logic          ovf;

    logic [7:0]  s_a_in;
    logic        s_a_vld_in;
    logic [7:0]  s_a_out;
    logic        s_a_vld_out;
    logic [7:0]  s_b_in;
    logic        s_b_vld_in;
    logic [7:0]  s_b_out;
    logic        s_b_vld_out;
    logic        s_clr;
    logic        s_drain;
    logic [15:0] s_d_in;
    logic        s_d_vld_in;
    logic [15:0] s_d_out;
    logic        s_d_vld_out;
    logic        s_busy;
    logic        s_ovf;

    int n_cmp;
    int n_err;

    systolic_mac_pe #(.DATA_W(8), .ACC_W(AW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ena       (ena),
        .a_in      (a_in),
        .a_vld_in  (a_vld_in),
        .a_out     (a_out),
        .a_vld_out (a_vld_out),
        .b_in      (b_in),
        .b_vld_in  (b_vld_in),
        .b_out     (b_out),
        .b_vld_out (b_vld_out),
        .clr       (clr),
        .drain     (drain),
        .d_in      (d_in),
        .d_vld_in  (d_vld_in),
        .d_out     (d_out),
        .d_vld_out (d_vld_out),
        .busy      (busy),
        .ovf       (ovf)
    );

    systolic_mac_pe #(.DATA_W(8), .ACC_W(16)) dut16 (
        .clk       (clk),
        .rst_n     (rst_n),
        .ena       (1'b1),
        .a_in      (s_a_in),
        .a_vld_in  (s_a_vld_in),
        .a_out     (s_a_out),
        .a_vld_out (s_a_vld_out),
        .b_in      (s_b_in),
        .b_vld_in  (s_b_vld_in),
        .b_out     (s_b_out),
        .b_vld_out (s_b_vld_out),
        .clr       (s_clr),
        .drain     (s_drain),
        .d_in      (s_d_in),
        .d_vld_in  (s_d_vld_in),
        .d_out     (s_d_out),
        .d_vld_out (s_d_vld_out),
        .busy      (s_busy),
        .ovf       (s_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // mode: 0 idle, 1 accumulating, 2 draining
    typedef struct {
        longint        acc;
        bit            ovf;
        int            mode;
        logic [AW-1:0] d;
        logic          dv;
    } mst_t;

    function automatic mst_t step(mst_t m, logic c, logic dr,
                                  logic av, logic bv,
                                  logic [7:0] a, logic [7:0] b,
                                  logic [AW-1:0] di, logic dvi);
        mst_t   n;
        longint s;
        n = m;
        if (c) begin
            n.acc  = 0;
            n.ovf  = 1'b0;
            n.dv   = 1'b0;
            n.mode = 0;
        end else if (m.mode == 2) begin
            n.dv = dvi;
            if (dvi) n.d = di;
            else n.mode = 0;
        end else begin
            if (av && bv) begin
                s = m.acc + longint'($signed(a)) * longint'($signed(b));
                if (s > MAXV || s < MINV) begin
`ifdef SYSTOLIC_PE_SATURATE_EN
                    s = (s > MAXV) ? MAXV : MINV;
                    n.ovf = 1'b1;
`else
                    s = ((s % MODV) + MODV) % MODV;
                    if (s > MAXV) s = s - MODV;
`endif
                end
                n.acc  = s;
                n.mode = 1;
            end
            n.dv = dr;
            if (dr) begin
                n.d    = AW'(n.acc);
                n.acc  = 0;
                n.mode = 2;
            end
        end
        return n;
    endfunction

    mst_t       m;
    logic [7:0] e_a;
    logic [7:0] e_b;
    logic       e_av;
    logic       e_bv;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m    <= '{acc: 0, ovf: 1'b0, mode: 0, d: '0, dv: 1'b0};
            e_a  <= '0;
            e_b  <= '0;
            e_av <= 1'b0;
            e_bv <= 1'b0;
        end else if (ena) begin
            m    <= step(m, clr, drain, a_vld_in, b_vld_in,
                         a_in, b_in, d_in, d_vld_in);
            e_a  <= a_in;
            e_b  <= b_in;
            e_av <= a_vld_in;
            e_bv <= b_vld_in;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("m_a_out", a_out, e_a);
            chk("m_a_vld", a_vld_out, e_av);
            chk("m_b_out", b_out, e_b);
            chk("m_b_vld", b_vld_out, e_bv);
            chk("m_d_out", d_out, m.d);
            chk("m_d_vld", d_vld_out, m.dv);
            chk("m_busy", busy, m.mode != 0);
            chk("m_ovf", ovf, m.ovf);
        end
    end

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic op(int a, int b);
        a_in     = 8'(a);
        b_in     = 8'(b);
        a_vld_in = 1'b1;
        b_vld_in = 1'b1;
    endtask

    task automatic nop();
        a_vld_in = 1'b0;
        b_vld_in = 1'b0;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        ena = 1'b1;
        a_in = '0; a_vld_in = 1'b0;
        b_in = '0; b_vld_in = 1'b0;
        clr = 1'b0; drain = 1'b0;
        d_in = '0; d_vld_in = 1'b0;
        s_a_in = '0; s_a_vld_in = 1'b0;
        s_b_in = '0; s_b_vld_in = 1'b0;
        s_clr = 1'b0; s_drain = 1'b0;
        s_d_in = '0; s_d_vld_in = 1'b0;
        repeat (3) cyc();
        chk("rst_a_out", a_out, 0);
        chk("rst_d_vld", d_vld_out, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ovf", ovf, 0);
        rst_n = 1'b1;

        // (3,4) + (-2,5) -> 2
        op(3, 4); cyc();
        op(-2, 5); cyc();
        nop(); drain = 1'b1; cyc();
        drain = 1'b0;
        chk("t1_d_out", d_out, 2);
        chk("t1_d_vld", d_vld_out, 1);
        chk("t1_busy", busy, 1);
        cyc();
        chk("t1_d_vld_drop", d_vld_out, 0);
        chk("t1_idle", busy, 0);

        // drain chain: own acc, 7, 9; operands forwarded not accumulated
        op(1, 1); cyc();
        nop(); drain = 1'b1; cyc();
        chk("t2_own", d_out, 1);
        a_in = 8'h55; b_in = 8'hAA;
        a_vld_in = 1'b1; b_vld_in = 1'b1;
        d_in = 7; d_vld_in = 1'b1;
        cyc();
        chk("t2_a_fwd", a_out, 8'h55);
        chk("t2_b_fwd", b_out, 8'hAA);
        chk("t2_d7", d_out, 7);
        chk("t2_d7_vld", d_vld_out, 1);
        nop(); drain = 1'b0; d_in = 9; cyc();
        chk("t2_d9", d_out, 9);
        chk("t2_d9_vld", d_vld_out, 1);
        d_vld_in = 1'b0; cyc();
        chk("t2_end_vld", d_vld_out, 0);
        chk("t2_end_idle", busy, 0);
        drain = 1'b1; cyc();
        drain = 1'b0;
        chk("t2_acc_kept", d_out, 0);
        cyc();

        // clr beats drain
        op(3, 4); cyc();
        nop(); clr = 1'b1; drain = 1'b1; cyc();
        clr = 1'b0; drain = 1'b0;
        chk("t3_no_vld", d_vld_out, 0);
        chk("t3_idle", busy, 0);
        drain = 1'b1; cyc();
        drain = 1'b0;
        chk("t3_acc_zero", d_out, 0);
        chk("t3_vld", d_vld_out, 1);
        cyc();

        // async reset mid-accumulation
        op(5, 5); cyc();
        nop(); drain = 1'b1; cyc();
        drain = 1'b0;
        chk("t4_pre", d_out, 25);
        cyc();
        op(2, 3); cyc();
        #2 rst_n = 1'b0;
        #1;
        chk("t4_a_out", a_out, 0);
        chk("t4_a_vld", a_vld_out, 0);
        chk("t4_b_out", b_out, 0);
        chk("t4_b_vld", b_vld_out, 0);
        chk("t4_d_out", d_out, 0);
        chk("t4_d_vld", d_vld_out, 0);
        chk("t4_busy", busy, 0);
        chk("t4_ovf", ovf, 0);
        nop();
        cyc();
        rst_n = 1'b1;
        drain = 1'b1; cyc();
        drain = 1'b0;
        chk("t4_drain", d_out, 0);
        chk("t4_drain_vld", d_vld_out, 1);
        cyc();

        // randomized traffic checked by the model
        for (int i = 0; i < 3000; i++) begin
            ena      = ($urandom_range(0, 9) != 0);
            a_in     = 8'($urandom);
            b_in     = 8'($urandom);
            a_vld_in = ($urandom_range(0, 3) != 0);
            b_vld_in = ($urandom_range(0, 3) != 0);
            clr      = ($urandom_range(0, 59) == 0);
            drain    = ($urandom_range(0, 11) == 0);
            d_in     = AW'($urandom);
            d_vld_in = ($urandom_range(0, 3) != 0);
            cyc();
        end
        ena = 1'b1; clr = 1'b0; drain = 1'b0;
        nop(); d_vld_in = 1'b0;
        cyc();

        // 16-bit accumulator overflow: 3 x 127*127
        s_a_in = 8'd127; s_b_in = 8'd127;
        s_a_vld_in = 1'b1; s_b_vld_in = 1'b1;
        repeat (3) cyc();
        s_a_vld_in = 1'b0; s_b_vld_in = 1'b0;
        s_drain = 1'b1; cyc();
        s_drain = 1'b0;
        chk("t5_vld", s_d_vld_out, 1);
`ifdef SYSTOLIC_PE_SATURATE_EN
        chk("t5_sat", s_d_out, 16'd32767);
        chk("t5_ovf", s_ovf, 1);
`else
        chk("t5_wrap", s_d_out, 16'hBD03);
        chk("t5_ovf", s_ovf, 0);
`endif
        cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
